// File: rtl/arith_pkg.sv
// arith_pkg: shared types and helpers for the lab arithmetic cells.
//   sub_state_t : control states of the serial subtractor
//   cnt_width() : counter width for N digit steps, never below 1 bit
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // A single-digit operation still needs a 1-bit counter so the
  // "last digit" compare has something to look at.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: single-bit A - B - Bin from two half-subtractor stages.
//   A, B  : operand bits
//   Bin   : borrow in
//   Diff  : A ^ B ^ Bin
//   Bout  : (~A & B) | (~(A ^ B) & Bin)
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs0 (
    .A    (A),
    .B    (B),
    .Diff (d1),
    .Bout (b1)
  );

  half_subtractor u_hs1 (
    .A    (d1),
    .B    (Bin),
    .Diff (Diff),
    .Bout (b2)
  );

  // The two stage borrows can never both be set.
  assign Bout = b1 | b2;

endmodule

// File: rtl/half_subtractor.sv
// half_subtractor: single-bit A - B.
//   A, B  : operand bits
//   Diff  : A ^ B
//   Bout  : borrow, set when A = 0 and B = 1
module half_subtractor (
  input  logic A,
  input  logic B,
  output logic Diff,
  output logic Bout
);

  assign Diff = A ^ B;
  assign Bout = ~A & B;

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle diff = a - b - bin, DIGIT bits per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, honoured only in IDLE or DONE
//   a, b, bin  : operands and borrow-in, captured on the accepting edge
//   busy       : high while digits are being processed
//   done       : one-cycle pulse, result valid
//   diff       : result modulo 2^WIDTH (holds until the next completion)
//   bout       : borrow-out, set iff a < b + bin (unsigned)
//   zero       : diff == 0
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int N  = (DIGIT > 0) ? WIDTH / DIGIT : 1;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_subtractor: WIDTH must be >= 1 and a multiple of DIGIT");
  end

  sub_state_t       state_q;
  sub_state_t       state_d;
  logic             accept;
  logic             last;

  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_next;
  logic             bor_q;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT-1:0] dig;
  logic [DIGIT:0]   chain_b;

  // Digit datapath: ripple of full subtractors fed by the borrow register.
  assign chain_b[0] = bor_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_chain
    full_subtractor u_fs (
      .A    (op_a_q[i]),
      .B    (op_b_q[i]),
      .Bin  (chain_b[i]),
      .Diff (dig[i]),
      .Bout (chain_b[i+1])
    );
  end

  // Result digits enter at the top so the first (lowest) digit ends up at
  // bit 0 after N steps.
  if (DIGIT == WIDTH) begin : g_sr_full
    assign sr_next = dig;
  end else begin : g_sr_shift
    assign sr_next = {dig, sr_q[WIDTH-1:DIGIT]};
  end

  // Control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_q == LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q <= '0;
      op_b_q <= '0;
      sr_q   <= '0;
      bor_q  <= 1'b0;
      cnt_q  <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      zero   <= 1'b0;
    end else if (accept) begin
      op_a_q <= a;
      op_b_q <= b;
      bor_q  <= bin;
      sr_q   <= '0;
      cnt_q  <= '0;
    end else if (state_q == RUN) begin
      op_a_q <= op_a_q >> DIGIT;
      op_b_q <= op_b_q >> DIGIT;
      sr_q   <= sr_next;
      bor_q  <= chain_b[DIGIT];
      cnt_q  <= cnt_q + CW'(1);
      // Published outputs only move on the final digit.
      if (last) begin
        diff <= sr_next;
        bout <= chain_b[DIGIT];
        zero <= (sr_next == '0);
      end
    end
  end

endmodule
